// File: rtl/mul_share_rr_arbiter_if.sv
// Handshake bundle for mul_share_rr_arbiter.
// It carries the per-requester operand channels and the single tagged response channel.
interface mul_share_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int A_W  = 11,
    parameter int B_W  = 8,
    parameter int P_W  = 19,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ*B_W-1:0] req_b;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [P_W-1:0]      rsp_data;
    logic                rsp_ready;

    // The arbiter drives this side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

    // The requesters and the response consumer drive this side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mul_share_rr_arbiter.sv
// mul_share_rr_arbiter: NREQ requesters share one signed A_W x B_W multiplier through a
// round-robin arbiter. The pipeline is an operand register, then MUL_LAT product stages,
// then an output register. The whole pipeline stalls only when the output is full and
// not taken by the consumer.
// Optional build macro MUL_SHARE_PERF_EN adds the perf_grants/perf_stalls counters.
module mul_share_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int A_W     = 11,
    parameter int B_W     = 8,
    parameter int P_W     = 19,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    mul_share_rr_arbiter_if.slave bus,
    output logic                  busy
`ifdef MUL_SHARE_PERF_EN
    ,
    output logic [31:0]           perf_grants,
    output logic [31:0]           perf_stalls
`endif
);
    localparam int unsigned N = NREQ;

    logic [ID_W-1:0]        ptr;
    logic                   s0_v;
    logic [ID_W-1:0]        s0_id;
    logic signed [A_W-1:0]  s0_a;
    logic signed [B_W-1:0]  s0_b;
    logic                   mv  [MUL_LAT];
    logic [ID_W-1:0]        mid [MUL_LAT];
    logic signed [P_W-1:0]  mp  [MUL_LAT];
    logic                   out_v;
    logic [ID_W-1:0]        out_id;
    logic [P_W-1:0]         out_p;

    logic                   adv;
    logic                   found;
    logic                   xfer;
    logic [ID_W-1:0]        gidx;
    logic [NREQ-1:0]        grant;
    logic [A_W-1:0]         sel_a;
    logic [B_W-1:0]         sel_b;
    logic signed [P_W-1:0]  prod;

    assign adv = !out_v || bus.rsp_ready;

    // Round-robin search: the first valid requester at or after ptr, wrapping to 0.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        gidx  = '0;
        grant = '0;
        sel_a = '0;
        sel_b = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                gidx       = ID_W'(idx);
                grant[idx] = 1'b1;
                sel_a      = bus.req_a[idx*A_W +: A_W];
                sel_b      = bus.req_b[idx*B_W +: B_W];
            end
        end
    end

    // Grants are shown only while the pipeline can advance and the block is out of reset.
    assign bus.req_ready = (adv && !ap_rst) ? grant : '0;
    assign xfer          = adv && found && !ap_rst;

    // Both operands are sign-extended to P_W first, so the product keeps full precision.
    assign prod = P_W'(s0_a) * P_W'(s0_b);

    // Pipeline advance and pointer update. All stages hold together while the output is blocked.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr    <= '0;
            s0_v   <= 1'b0;
            s0_id  <= '0;
            s0_a   <= '0;
            s0_b   <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                mv[i]  <= 1'b0;
                mid[i] <= '0;
                mp[i]  <= '0;
            end
            out_v  <= 1'b0;
            out_id <= '0;
            out_p  <= '0;
        end else if (adv) begin
            s0_v <= xfer;
            if (xfer) begin
                s0_id <= gidx;
                s0_a  <= sel_a;
                s0_b  <= sel_b;
                ptr   <= (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + ID_W'(1);
            end
            mv[0]  <= s0_v;
            mid[0] <= s0_id;
            mp[0]  <= prod;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                mv[i]  <= mv[i-1];
                mid[i] <= mid[i-1];
                mp[i]  <= mp[i-1];
            end
            out_v  <= mv[MUL_LAT-1];
            out_id <= mid[MUL_LAT-1];
            out_p  <= mp[MUL_LAT-1];
        end
    end

    assign bus.rsp_valid = out_v;
    assign bus.rsp_id    = out_id;
    assign bus.rsp_data  = out_p;

    // busy is high while any stage, including the output register, holds a valid entry.
    always_comb begin
        busy = s0_v | out_v;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            busy = busy | mv[i];
        end
    end

`ifdef MUL_SHARE_PERF_EN
    // Count transfers, and count cycles with pending requests that saw no transfer. Both wrap at 2^32.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else if (xfer) begin
            perf_grants <= perf_grants + 32'd1;
        end else if (|bus.req_valid) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mul_share_rr_arbiter.sv
// Self-checking bench for mul_share_rr_arbiter. The stimulus is random, plus directed corner phases.
// A behavioural model tracks the grant order, the pipeline occupancy and the products.
module tb_mul_share_rr_arbiter;
    localparam int NREQ    = 4;
    localparam int A_W     = 11;
    localparam int B_W     = 8;
    localparam int P_W     = 19;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 2;
    localparam int D       = MUL_LAT + 2;

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic busy;
`ifdef MUL_SHARE_PERF_EN
    logic [31:0] perf_grants;
    logic [31:0] perf_stalls;
`endif

    mul_share_rr_arbiter_if #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)) bus ();

    mul_share_rr_arbiter #(
        .NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .bus         (bus),
        .busy        (busy)
`ifdef MUL_SHARE_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model state
    typedef struct { bit v; int id; int p; } slot_t;
    slot_t pipe [D];
    int    ptr;
    int    m_grants;
    int    m_stalls;
    bit    vld [NREQ];
    int    ra  [NREQ];
    int    rb  [NREQ];
    int    req_mode;   // 0: no new requests, 1: all requesters valid, 2: random
    int    rdy_mode;   // 0: rsp_ready low, 1: high, 2: random
    bit    rdy;
    int    last_grant;

    function automatic int rand_a();
        int k;
        if ($urandom_range(0, 3) == 0) begin
            k = int'($urandom_range(0, 3));
            case (k)
                0:       return -1024;
                1:       return 1023;
                2:       return 0;
                default: return -1;
            endcase
        end
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    function automatic int rand_b();
        int k;
        if ($urandom_range(0, 3) == 0) begin
            k = int'($urandom_range(0, 3));
            case (k)
                0:       return -128;
                1:       return 127;
                2:       return 0;
                default: return -1;
            endcase
        end
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic pack_bus();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]           = vld[i];
            bus.req_a[i*A_W +: A_W]    = A_W'(ra[i]);
            bus.req_b[i*B_W +: B_W]    = B_W'(rb[i]);
        end
        bus.rsp_ready = rdy;
    endtask

    task automatic model_reset();
        ptr      = 0;
        m_grants = 0;
        m_stalls = 0;
        for (int j = 0; j < D; j++) pipe[j] = '{1'b0, 0, 0};
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'b0;
            ra[i]  = 0;
            rb[i]  = 0;
        end
        pack_bus();
    endtask

    // One clock cycle. It starts at a negedge: drive the inputs, check the outputs, then step the model at the posedge.
    task automatic cycle();
        int  g;
        int  i;
        int  exp_ready;
        bit  adv;
        bit  any;
        bit  occ;
        for (int k = 0; k < NREQ; k++) begin
            if (!vld[k] && (req_mode == 1 || (req_mode == 2 && $urandom_range(0, 2) == 0))) begin
                vld[k] = 1'b1;
                ra[k]  = rand_a();
                rb[k]  = rand_b();
            end
        end
        rdy = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        pack_bus();
        #1;
        adv = !pipe[D-1].v || rdy;
        g   = -1;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            i = (ptr + k) % NREQ;
            if (vld[i]) any = 1'b1;
            if (adv && g < 0 && vld[i]) g = i;
        end
        exp_ready = (g >= 0) ? (1 << g) : 0;
        check("req_ready", int'(bus.req_ready), exp_ready);
        last_grant = -1;
        for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) last_grant = k;
        check("rsp_valid", int'(bus.rsp_valid), int'(pipe[D-1].v));
        if (pipe[D-1].v) begin
            check("rsp_id", int'(bus.rsp_id), pipe[D-1].id);
            check("rsp_data", int'($signed(bus.rsp_data)), pipe[D-1].p);
        end
        occ = 1'b0;
        for (int j = 0; j < D; j++) occ = occ | pipe[j].v;
        check("busy", int'(busy), int'(occ));
`ifdef MUL_SHARE_PERF_EN
        check("perf_grants", int'(perf_grants), m_grants);
        check("perf_stalls", int'(perf_stalls), m_stalls);
`endif
        @(posedge ap_clk);
        if (adv) begin
            for (int j = D - 1; j > 0; j--) pipe[j] = pipe[j-1];
            if (g >= 0) begin
                pipe[0] = '{1'b1, g, ra[g] * rb[g]};
                ptr     = (g + 1) % NREQ;
                vld[g]  = 1'b0;
                m_grants++;
            end else begin
                pipe[0] = '{1'b0, 0, 0};
            end
        end
        if (any && g < 0) m_stalls++;
        @(negedge ap_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ap_rst   = 1'b1;
        req_mode = 0;
        rdy_mode = 1;
        rdy      = 1'b1;
        model_reset();
        bus.req_valid = '1;
        repeat (2) @(negedge ap_clk);
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_rsp_id", int'(bus.rsp_id), 0);
        check("rst_rsp_data", int'(bus.rsp_data), 0);
        check("rst_busy", int'(busy), 0);
        bus.req_valid = '0;
        ap_rst = 1'b0;

        // Single request: requester 2, the largest positive product
        vld[2] = 1'b1; ra[2] = -1024; rb[2] = -128;
        cycle();
        check("single_grant", last_grant, 2);
        vld[0] = 1'b1; ra[0] = 1023; rb[0] = 127;
        vld[3] = 1'b1; ra[3] = -1024; rb[3] = 127;
        cycle();
        check("ptr_after_2", last_grant, 3);
        repeat (MUL_LAT - 1) cycle();
        check("lat_early", int'(bus.rsp_valid), 0);
        cycle();
        check("lat_valid", int'(bus.rsp_valid), 1);
        check("lat_id", int'(bus.rsp_id), 2);
        check("lat_data", int'($signed(bus.rsp_data)), 131072);

        // Reset between edges with entries in flight
        vld[0] = 1'b1; ra[0] = 0;  rb[0] = -128;
        vld[1] = 1'b1; ra[1] = -1; rb[1] = -1;
        cycle();
        cycle();
        #2;
        ap_rst = 1'b1;
        #1;
        check("async_rsp_valid", int'(bus.rsp_valid), 0);
        check("async_busy", int'(busy), 0);
        model_reset();
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // Round-robin: all requesters valid, no backpressure
        req_mode = 1;
        rdy_mode = 1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_order", last_grant, k % NREQ);
        end

        // Backpressure for 5 cycles, then release
        rdy_mode = 0;
        repeat (5) cycle();
        rdy_mode = 1;
        repeat (8) cycle();

        // Random traffic
        req_mode = 2;
        rdy_mode = 2;
        repeat (400) cycle();

        // Drain
        req_mode = 0;
        rdy_mode = 1;
        repeat (NREQ + D + 2) cycle();

`ifdef MUL_SHARE_PERF_EN
        ap_rst = 1'b1;
        model_reset();
        @(negedge ap_clk);
        ap_rst = 1'b0;
        req_mode = 1;
        rdy_mode = 1;
        repeat (10) cycle();
        rdy_mode = 0;
        repeat (3) cycle();
        check("perf_grants_10", int'(perf_grants), 10);
        check("perf_stalls_3", int'(perf_stalls), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_share_rr_arbiter.md
Name: mul_share_rr_arbiter

Overview:
- Shares one signed 11-bit x 8-bit -> 19-bit multiplier datapath among NREQ requesters.
- Each requester has a valid/ready operand channel; the single response channel returns the full-precision product tagged with the requester index.
- Sits between time-multiplexed dense-layer lanes and one shared multiplier instance, cutting DSP count when lanes are underutilised.

Parameters:
- NREQ, 4, number of requesters (2..16)
- A_W, 11, width of signed operand A
- B_W, 8, width of signed operand B
- P_W, 19, product width; must equal A_W+B_W
- ID_W, 2, tag width; must equal clog2(NREQ), minimum 1
- MUL_LAT, 1, register stages after the operand register (1..4)

Ports:
- ap_clk  in  1  clock; all state on the rising edge
- ap_rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*A_W  packed signed A operands; requester i uses bits [i*A_W +: A_W]
- req_b  in  NREQ*B_W  packed signed B operands; same packing as req_a
- rsp_valid  out  1  product valid
- rsp_id  out  ID_W  index of the requester that owns rsp_data
- rsp_data  out  P_W  signed product A*B
- rsp_ready  in  1  consumer accepts the response
- busy  out  1  high while any pipeline stage holds a valid entry

Behaviour:
- Reset (asynchronous): req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - All pipeline valid bits clear.
  - Round-robin pointer resets to 0.
  - In-flight data is discarded; no response is produced for it.
- Pipeline: S0 operand register -> MUL_LAT product stages -> output register. The output register drives the rsp_* ports directly.
- Latency: accepted on edge k -> rsp_valid on edge k+1+MUL_LAT, if there is no backpressure.
- Stall: the whole pipeline advances only when the output register is empty or rsp_ready=1.
  - While stalled, all stages hold their values and req_ready is 0 for every requester.
- Arbitration is round-robin and combinational from req_valid and the pointer.
  - Search order starts at the pointer and wraps from NREQ-1 to 0.
  - The first valid requester gets req_ready=1, but only if the pipeline advances this cycle.
  - A transfer happens when req_valid[i] and req_ready[i] are both high.
  - On a transfer, the pointer becomes (i+1) mod NREQ. With no transfer, the pointer holds.
- Fairness: a requester holding valid is granted within NREQ transfers.
- Requester rules:
  - A requester must hold valid and its operands stable until the transfer.
  - req_ready never depends on that requester's own operands.
- Arithmetic: full-precision signed multiply, sign-extended to P_W; no rounding or saturation.
  - -1024 * -128 = 131072 fits in 19 bits.
- Response handshake: rsp_data and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous events: with rsp_valid=1 and rsp_ready=1 on the same edge a new entry arrives, the output register reloads with no bubble. Throughput is 1 product per cycle.
- busy = OR of all stage valid bits, including the output register.

Optional Feature:
- Macro: MUL_SHARE_PERF_EN.
- When defined, adds output ports:
  - perf_grants (32): count of transfers
  - perf_stalls (32): cycles where any req_valid=1 but no transfer happened
  - Both counters reset to 0 on ap_rst, wrap modulo 2^32, and update on the same edge as the event.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: after reset, only requester 2 is valid with A=-1024, B=-128 -> transfer in cycle 0; rsp_valid at edge 1+MUL_LAT with rsp_id=2, rsp_data=131072; pointer=3.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; one response per cycle; pointer wraps from 3 to 0.
- Backpressure: rsp_ready=0 for 5 cycles with entries in flight -> all req_ready=0, rsp_data and rsp_id held; after release, responses emerge in order with none lost or duplicated.
- Signed corners: (1023,127)->129921, (-1024,127)->-130048, (0,-128)->0, (-1,-1)->1; each is bit-exact at P_W=19.
- Reset mid-operation: assert ap_rst asynchronously (between edges) with 2 entries in flight -> rsp_valid=0 and busy=0 immediately; no stale response after release; first grant goes to requester 0.
- MUL_SHARE_PERF_EN defined: 10 transfers plus 3 stalled cycles -> perf_grants=10, perf_stalls=3.
